// File: rtl/gt4.sv
// 4-bit unsigned greater-than comparator built from two 2-bit sum-of-products slices; no relational operators.
// Latency: 1 cycle (2 cycles when GT4_IN_REG_EN is defined, which adds an input register stage).
// Backpressure: none; the output register updates on every rising clk edge.

module gt4_slice2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       eq
);
    assign gt = (a[1] & ~b[1])
              | (a[1] &  a[0] & ~b[0])
              | (a[0] & ~b[1] & ~b[0]);

    assign eq = (~a[1] & ~a[0] & ~b[1] & ~b[0])
              | (~a[1] &  a[0] & ~b[1] &  b[0])
              | ( a[1] & ~a[0] &  b[1] & ~b[0])
              | ( a[1] &  a[0] &  b[1] &  b[0]);
endmodule

module gt4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       agtb
);
    logic [3:0] a_cmp;
    logic [3:0] b_cmp;
    logic       gt_hi;
    logic       eq_hi;
    logic       gt_lo;
    logic       eq_lo_unused;
    logic       gt_all;

`ifdef GT4_IN_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cmp <= 4'd0;
            b_cmp <= 4'd0;
        end else begin
            a_cmp <= a;
            b_cmp <= b;
        end
    end
`else
    assign a_cmp = a;
    assign b_cmp = b;
`endif

    gt4_slice2 u_hi (
        .a  (a_cmp[3:2]),
        .b  (b_cmp[3:2]),
        .gt (gt_hi),
        .eq (eq_hi)
    );

    // Low-slice equality is never needed for a strict greater-than.
    gt4_slice2 u_lo (
        .a  (a_cmp[1:0]),
        .b  (b_cmp[1:0]),
        .gt (gt_lo),
        .eq (eq_lo_unused)
    );

    assign gt_all = gt_hi | (eq_hi & gt_lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            agtb <= 1'b0;
        end else begin
            agtb <= gt_all;
        end
    end
endmodule

// File: tb/tb_gt4.sv
// Scoreboard bench for gt4: stimulus pushes expected results, a monitor pops and compares at build latency.
module tb_gt4;
`ifdef GT4_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic  exp;
        string tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       agtb;
    logic       issued;
    logic [3:0] hist;
    exp_t       sb_q[$];
    int         checks;
    int         errors;

    gt4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .agtb  (agtb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track which cycles carried scoreboard vectors so results are popped exactly LAT edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 4'd0;
        else        hist <= {hist[2:0], issued};
    end

    always @(negedge clk) begin
        if (rst_n && hist[LAT-1]) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: agtb=%0b with no expected entry", agtb);
            end else begin
                e = sb_q.pop_front();
                if (agtb !== e.exp) begin
                    errors++;
                    $display("FAIL %s: agtb=%0b expected %0b", e.tag, agtb, e.exp);
                end
            end
        end
    end

    task automatic apply(input logic [3:0] av, input logic [3:0] bv, input logic ev, input string tag);
        exp_t e;
        @(negedge clk);
        a = av;
        b = bv;
        issued = 1'b1;
        e.exp = ev;
        e.tag = $sformatf("%s a=%0d b=%0d", tag, av, bv);
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        issued = 1'b0;
    endtask

    task automatic check_now(input logic ev, input string tag);
        checks++;
        if (agtb !== ev) begin
            errors++;
            $display("FAIL %s: agtb=%0b expected %0b", tag, agtb, ev);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", sb_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        issued = 1'b0;
        a = 4'd15;
        b = 4'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_now(1'b0, "reset_async");
        repeat (2) @(posedge clk);
        #1 check_now(1'b0, "reset_held_with_clk");
        @(negedge clk);
        rst_n = 1'b1;
        issued = 1'b0;

        // Exhaustive sweep, one pair per cycle.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                apply(4'(i), 4'(j), (i > j), "sweep");
            end
        end

        apply(4'd9,  4'd9,  1'b0, "eq_9_9");
        apply(4'd0,  4'd0,  1'b0, "eq_0_0");
        apply(4'd15, 4'd15, 1'b0, "eq_15_15");
        apply(4'd15, 4'd0,  1'b1, "max_gt_min");
        apply(4'd0,  4'd15, 1'b0, "min_gt_max");
        apply(4'd8,  4'd7,  1'b1, "hi_slice_gt");
        apply(4'd7,  4'd8,  1'b0, "hi_slice_lt");
        apply(4'd6,  4'd5,  1'b1, "lo_slice_gt");
        apply(4'd5,  4'd6,  1'b0, "lo_slice_lt");
        for (int k = 0; k < 4; k++) begin
            apply(4'd3,  4'd7, 1'b0, "latency_lo");
            apply(4'd12, 4'd7, 1'b1, "latency_hi");
        end
        idle();
        drain();

        // Async reset mid-operation.
        @(negedge clk);
        a = 4'd15;
        b = 4'd0;
        for (int n = 0; n < 8 && agtb !== 1'b1; n++) @(negedge clk);
        check_now(1'b1, "pre_reset_high");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_now(1'b0, "reset_mid_op");
        @(posedge clk);
        #1 check_now(1'b0, "reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd15, 4'd0, 1'b1, "post_reset");
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gt4.md
GT4 -- requirements
Module: gt4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  4  unsigned operand A.
REQ-005 b  input  4  unsigned operand B.
REQ-006 agtb  output  1  registered result, 1 when A > B, else 0.

Function
REQ-007 The compare function SHALL be unsigned: agtb = 1 if and only if a > b numerically, over all 256 (a, b) pairs.
REQ-008 The comparison logic SHALL be structural gate-level, with no relational operator.
REQ-009 The comparison logic SHALL be split into two 2-bit slices (hi = bits 3:2, lo = bits 1:0).
REQ-010 Each 2-bit slice SHALL produce a gt flag and an eq flag.
REQ-011 The combined result SHALL be gt = gt_hi OR (eq_hi AND gt_lo).
REQ-012 Each 2-bit slice SHALL be built from sum-of-products of its four input bits.
REQ-013 agtb SHALL be a registered output: the result for inputs sampled at rising edge N SHALL appear on agtb after edge N (latency 1 cycle, default build).
REQ-014 The output register SHALL update on every edge; there is no enable or hold.
REQ-015 Boundaries: a = b (any value, including 0/0 and 15/15) SHALL give 0; a = 15, b = 0 SHALL give 1; a = 0, b = 15 SHALL give 0.
REQ-016 Inputs changing between clock edges SHALL NOT affect agtb until the next rising edge.
REQ-017 No glitches SHALL be visible on agtb.
REQ-018 agtb SHALL be a pure function of the sampled inputs, with no history dependence.

Reset
REQ-019 While rst_n = 0, agtb SHALL be 0, asynchronously and independent of clk.
REQ-020 Any pipeline register SHALL also clear to 0 while rst_n = 0.
REQ-021 On release, the first rising edge with rst_n = 1 SHALL sample a and b normally.
REQ-022 Reset asserted mid-operation SHALL immediately force agtb to 0 and discard any in-flight result.

Configuration
REQ-023 Macro GT4_IN_REG_EN SHALL control an input register stage.
REQ-024 With GT4_IN_REG_EN defined, a and b SHALL be registered before the compare logic, and agtb SHALL follow with total latency 2 cycles.
REQ-025 With GT4_IN_REG_EN defined, the input registers SHALL reset to 0, so post-reset agtb remains 0 until real data propagates.
REQ-026 Without GT4_IN_REG_EN, the compare logic SHALL take a and b directly, with latency 1 cycle per REQ-013.
REQ-027 The port list SHALL be identical in both builds.

Verification
REQ-028 Exhaustive sweep: a = 0..15 nested with b = 0..15, one pair per cycle. Required: agtb equals (a > b) delayed by the build latency, for all 256 pairs.
REQ-029 Equality: a = 9, b = 9, then a = 0, b = 0, then a = 15, b = 15. Required: agtb = 0 each time.
REQ-030 Upper-slice decides: a = 8, b = 7. Required: agtb = 1. Then a = 7, b = 8. Required: agtb = 0.
REQ-031 Lower-slice decides: a = 6, b = 5. Required: agtb = 1. Then a = 5, b = 6. Required: agtb = 0.
REQ-032 Async reset: drive a = 15, b = 0 until agtb = 1, then drop rst_n between edges. Required: agtb = 0 at once. After rst_n returns to 1, agtb = 1 after the build latency.
REQ-033 Latency: toggle a between 3 and 12 with b = 7. Required: agtb toggles 0/1 exactly 1 cycle later (2 cycles with GT4_IN_REG_EN).
